timer_peripheral: RTL and testbench
===================================

# timer_peripheral

Memory-mapped peripheral responder on the core data bus. It decodes the core's address, write and read strobes and write data, returns read data, and drives the core's interrupt input. It contains a reloadable interval timer with interrupt, an LED output register, a switch input port, a 7-segment drive register and an optional free-running tick counter. It sits beside data RAM, and the top level muxes its read data onto the core's read-data bus.

## Interface
Parameters:
- BASE_ADDR, 32'h40000000, base of the 7-word register window.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- iMemAddr  input  32  byte address from the core.
- iMemWrite  input  1  write strobe, one cycle per store.
- iMemRead  input  1  read strobe.
- iMemWriteData  input  32  store data.
- oMemReadData  output  32  load data, combinational.
- oInterrupt  output  1  timer interrupt request to the core.
- oLed  output  8  LED register.
- iSwitch  input  8  asynchronous board switches.
- oDigi  output  12  7-segment drive, as [11:8] anode select and [7:0] segments.

## Operation
- Decode: hit when iMemAddr[31:5] matches BASE_ADDR[31:5] and offset iMemAddr[4:2] ≤ 6. Bits [1:0] are ignored.
- Register offsets:
  - 0x00 TH: R/W, 32-bit reload value.
  - 0x04 TL: R/W, 32-bit counter.
  - 0x08 TCON: R/W [2:0]. Bit 0 = timer enable, bit 1 = interrupt enable, bit 2 = interrupt status. Bits [31:3] read 0.
  - 0x0C LED: R/W [7:0].
  - 0x10 SWITCH: RO [7:0], the synchronized switches. Writes are ignored.
  - 0x14 DIGI: R/W [11:0].
  - 0x18 SYSTICK: R/W, 32-bit; see Configuration.
- Timer, each clock with TCON[0]=1:
  - If TL==32'hFFFFFFFF: TL←TH, and if TCON[1]=1 then TCON[2]←1.
  - Otherwise TL←TL+1. The increment is 32-bit modulo.
- Interrupt: oInterrupt = TCON[2]. It stays high until software writes TCON with bit 2 = 0.
- Switch input: passed through a two-flop synchronizer before becoming readable.
- Read: oMemReadData is the addressed register when iMemRead=1 and the address hits; otherwise 32'h0. Unused upper bits read 0.
- Write: when iMemWrite=1 and the address hits a writable register, the register takes iMemWriteData (truncated to its width) on the rising edge.
- Unmapped offsets (0x1C) and all non-hit addresses: reads return 0, writes are ignored.

## Timing
- Reset (reset=0, asynchronous): TH=0, TL=0, TCON=0, LED=0, DIGI=0, SYSTICK=0, synchronizer flops=0.
  - Outputs during reset: oInterrupt=0, oLed=8'h00, oDigi=12'h000, oMemReadData follows decode (0 if no read).
  - Reset mid-count clears everything immediately. Counting resumes only after software sets TCON[0].
- Read latency: 0 cycles, combinational in the same cycle as iMemRead, as the single-cycle core requires.
- Write latency: the value is visible from the cycle after the strobe edge.
- Switch latency: a change on iSwitch is readable 2 rising edges later.
- Simultaneous events:
  - Bus write to TL in the same cycle as an increment or reload: the bus write wins.
  - Bus write to TH in the same cycle as a reload: TL takes the old TH.
  - TCON write clearing bit 2 in the same cycle as an overflow that sets it: the set wins, so the interrupt is not lost. The written bits 0 and 1 still take effect.
  - TCON write that sets bit 2 to 1: allowed; software can force an interrupt.
- The timer overflow period is (2^32 − TH) cycles after the first reload.

## Configuration
- Macro TIMER_PERIPHERAL_SYSTICK_EN.
  - Defined: SYSTICK increments by 1 every clock, wrapping at 2^32. A bus write to 0x18 loads iMemWriteData, and the write wins over the increment.
  - Undefined: no SYSTICK flops are built. Offset 0x18 reads 32'h0 and writes are ignored. All other behaviour is identical.

## Test plan
- Reset and defaults: hold reset=0 for 3 cycles mid-activity, then release. Read each register:
  - 0x40000000 through 0x40000014 read 0.
  - oInterrupt=0, oLed=0, oDigi=0.
- Timer overflow: write TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3.
  - TL reads FFFFFFFF one cycle later.
  - On the next edge TL=FFFFFFFC and oInterrupt=1.
  - The next overflow occurs 4 cycles later.
- Interrupt clear race: arrange an overflow on the same edge as a write TCON=3.
  - oInterrupt stays 1.
  - A later write TCON=3 with no overflow drops oInterrupt to 0.
- Interrupt-enable off: TCON=1 with TL=FFFFFFFF. After the edge TL=TH and oInterrupt stays 0.
- LED, DIGI, switch:
  - Write 0x4000000C=32'h1A5: oLed=8'hA5.
  - Write 0x40000014=32'hFABC: oDigi=12'hABC.
  - Set iSwitch=8'h3C: a read of 0x40000010 returns 32'h3C exactly 2 edges later.
- Decode and SYSTICK:
  - A read of 0x4000001C or 0x50000000 returns 0, and a write there changes nothing.
  - With TIMER_PERIPHERAL_SYSTICK_EN: write 0x18=100, then read 103 three cycles later.
  - Without the macro: 0x18 reads 0.

Source files
------------

// File: rtl/timer_peripheral.sv
// timer_peripheral: memory-mapped responder on the core data bus.
// It provides a reloadable interval timer with interrupt, an LED register, a
// synchronized switch port, a 7-segment drive register and, when the macro
// TIMER_PERIPHERAL_SYSTICK_EN is defined, a free-running SYSTICK counter.
// Register window (7 words from BASE_ADDR):
//   0x00 TH  0x04 TL  0x08 TCON  0x0C LED  0x10 SWITCH  0x14 DIGI  0x18 SYSTICK
// Reads are combinational so the single-cycle core sees data in the same cycle.
module timer_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iMemAddr,
    input  logic        iMemWrite,
    input  logic        iMemRead,
    input  logic [31:0] iMemWriteData,
    output logic [31:0] oMemReadData,
    output logic        oInterrupt,
    output logic [7:0]  oLed,
    input  logic [7:0]  iSwitch,
    output logic [11:0] oDigi
);

    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_LED     = 3'd3;
    localparam logic [2:0] OFF_SWITCH  = 3'd4;
    localparam logic [2:0] OFF_DIGI    = 3'd5;
    localparam logic [2:0] OFF_SYSTICK = 3'd6;

    localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

    // Register state and next-state values
    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [7:0]  sw_meta_q;
    logic [7:0]  sw_sync_q;

    // Address decode
    logic        hit;
    logic [2:0]  offset;
    logic        wr_en;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        wr_led;
    logic        wr_digi;

    // Timer events
    logic        tl_at_max;
    logic        tmr_reload;
    logic        tmr_inc;
    logic        irq_set;

    // Byte-lane bits are not part of the word decode
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^iMemAddr[1:0];

    // Word offset 7 lies inside the 32-byte window but is not a register
    assign offset  = iMemAddr[4:2];
    assign hit     = (iMemAddr[31:5] == BASE_ADDR[31:5]) && (offset != 3'd7);
    assign wr_en   = iMemWrite && hit;
    assign wr_th   = wr_en && (offset == OFF_TH);
    assign wr_tl   = wr_en && (offset == OFF_TL);
    assign wr_tcon = wr_en && (offset == OFF_TCON);
    assign wr_led  = wr_en && (offset == OFF_LED);
    assign wr_digi = wr_en && (offset == OFF_DIGI);

    // Overflow uses the currently stored enables; a same-cycle TCON write
    // only affects the following cycle.
    assign tl_at_max  = (tl_q == TL_MAX);
    assign tmr_reload = tcon_q[0] && tl_at_max;
    assign tmr_inc    = tcon_q[0] && !tl_at_max;
    assign irq_set    = tmr_reload && tcon_q[1];

`ifdef TIMER_PERIPHERAL_SYSTICK_EN
    logic [31:0] systick_q, systick_d;
    logic        wr_systick;

    assign wr_systick = wr_en && (offset == OFF_SYSTICK);

    // SYSTICK free-runs; a bus write takes priority over the increment
    always_comb begin
        systick_d = systick_q + 32'd1;
        if (wr_systick) begin
            systick_d = iMemWriteData;
        end
    end

    // SYSTICK storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick_q <= '0;
        end else begin
            systick_q <= systick_d;
        end
    end
`endif

    // Timer next state: bus writes to TL win, reload reads the old TH, and an
    // overflow set of the status bit wins over a software clear.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;

        if (wr_th) begin
            th_d = iMemWriteData;
        end

        if (wr_tl) begin
            tl_d = iMemWriteData;
        end else if (tmr_reload) begin
            tl_d = th_q;
        end else if (tmr_inc) begin
            tl_d = tl_q + 32'd1;
        end

        if (wr_tcon) begin
            tcon_d = iMemWriteData[2:0];
        end
        if (irq_set) begin
            tcon_d[2] = 1'b1;
        end
    end

    // Simple output registers next state
    always_comb begin
        led_d  = led_q;
        digi_d = digi_q;
        if (wr_led) begin
            led_d = iMemWriteData[7:0];
        end
        if (wr_digi) begin
            digi_d = iMemWriteData[11:0];
        end
    end

    // Timer and output register storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            led_q  <= '0;
            digi_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            digi_q <= digi_d;
        end
    end

    // Two-flop synchronizer for the asynchronous board switches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= iSwitch;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Combinational read mux; zero whenever the access is not a read hit
    always_comb begin
        oMemReadData = '0;
        if (iMemRead && hit) begin
            case (offset)
                OFF_TH:      oMemReadData = th_q;
                OFF_TL:      oMemReadData = tl_q;
                OFF_TCON:    oMemReadData = {29'd0, tcon_q};
                OFF_LED:     oMemReadData = {24'd0, led_q};
                OFF_SWITCH:  oMemReadData = {24'd0, sw_sync_q};
                OFF_DIGI:    oMemReadData = {20'd0, digi_q};
`ifdef TIMER_PERIPHERAL_SYSTICK_EN
                OFF_SYSTICK: oMemReadData = systick_q;
`else
                OFF_SYSTICK: oMemReadData = 32'd0;
`endif
                default:     oMemReadData = 32'd0;
            endcase
        end
    end

    assign oInterrupt = tcon_q[2];
    assign oLed       = led_q;
    assign oDigi      = digi_q;

endmodule

// File: tb/tb_timer_peripheral.sv
// Self-checking bench for timer_peripheral. Expected read data is queued
// when the stimulus is set up and popped when the bus returns data.
module tb_timer_peripheral;

    localparam logic [31:0] BASE = 32'h40000000;
    localparam logic [31:0] A_TH      = BASE + 32'h00;
    localparam logic [31:0] A_TL      = BASE + 32'h04;
    localparam logic [31:0] A_TCON    = BASE + 32'h08;
    localparam logic [31:0] A_LED     = BASE + 32'h0C;
    localparam logic [31:0] A_SWITCH  = BASE + 32'h10;
    localparam logic [31:0] A_DIGI    = BASE + 32'h14;
    localparam logic [31:0] A_SYSTICK = BASE + 32'h18;
    localparam logic [31:0] A_UNMAP   = BASE + 32'h1C;

    logic        clk;
    logic        reset;
    logic [31:0] iMemAddr;
    logic        iMemWrite;
    logic        iMemRead;
    logic [31:0] iMemWriteData;
    logic [31:0] oMemReadData;
    logic        oInterrupt;
    logic [7:0]  oLed;
    logic [7:0]  iSwitch;
    logic [11:0] oDigi;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] exp;

    timer_peripheral #(.BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .iMemAddr     (iMemAddr),
        .iMemWrite    (iMemWrite),
        .iMemRead     (iMemRead),
        .iMemWriteData(iMemWriteData),
        .oMemReadData (oMemReadData),
        .oInterrupt   (oInterrupt),
        .oLed         (oLed),
        .iSwitch      (iSwitch),
        .oDigi        (oDigi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    // Called at a negedge: strobe spans exactly one rising edge, returns at the next negedge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        iMemAddr      = a;
        iMemWriteData = d;
        iMemWrite     = 1'b1;
        @(negedge clk);
        iMemWrite     = 1'b0;
        iMemAddr      = 32'h0;
        iMemWriteData = 32'h0;
    endtask

    // Combinational read sampled mid low-phase, no clock consumed
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        iMemAddr = a;
        iMemRead = 1'b1;
        #1;
        d = oMemReadData;
        iMemRead = 1'b0;
        iMemAddr = 32'h0;
    endtask

    // Pop the oldest expectation and compare it against a read of address a
    task automatic sb_read(input logic [31:0] a, input string name);
        bus_read(a, got);
        exp = exp_q.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: read %h, expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        // Activity first: running timer about to overflow, LED and DIGI set
        bus_write(A_LED, 32'h55);
        bus_write(A_DIGI, 32'h123);
        bus_write(A_TH, 32'h10);
        bus_write(A_TL, 32'hFFFFFFFF);
        bus_write(A_TCON, 32'h3);
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (oInterrupt !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_irq: got %b, expected 0", oInterrupt);
        end
        n_vec++;
        if (oLed !== 8'h00) begin
            n_miss++;
            $display("FAIL reset_led: got %h, expected 00", oLed);
        end
        n_vec++;
        if (oDigi !== 12'h000) begin
            n_miss++;
            $display("FAIL reset_digi: got %h, expected 000", oDigi);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h0);
        for (int i = 0; i < 6; i++) sb_read(BASE + 32'(4 * i), "reset_reg");
        // Timer must not resume after reset
        @(negedge clk);
        exp_q.push_back(32'h0);
        sb_read(A_TL, "reset_tl_idle");
    endtask

    task automatic test_overflow();
        bus_write(A_TH, 32'hFFFFFFFC);
        bus_write(A_TL, 32'hFFFFFFFE);
        bus_write(A_TCON, 32'h3);
        exp_q.push_back(32'hFFFFFFFE);
        sb_read(A_TL, "ovf_tl_start");
        @(negedge clk);
        exp_q.push_back(32'hFFFFFFFF);
        sb_read(A_TL, "ovf_tl_max");
        n_vec++;
        if (oInterrupt !== 1'b0) begin
            n_miss++;
            $display("FAIL ovf_irq_before: got %b, expected 0", oInterrupt);
        end
        @(negedge clk);
        exp_q.push_back(32'hFFFFFFFC);
        sb_read(A_TL, "ovf_tl_reload");
        n_vec++;
        if (oInterrupt !== 1'b1) begin
            n_miss++;
            $display("FAIL ovf_irq_set: got %b, expected 1", oInterrupt);
        end
        repeat (3) @(negedge clk);
        exp_q.push_back(32'hFFFFFFFF);
        sb_read(A_TL, "ovf2_tl_max");
        @(negedge clk);
        exp_q.push_back(32'hFFFFFFFC);
        sb_read(A_TL, "ovf2_tl_reload");
        exp_q.push_back(32'h7);
        sb_read(A_TCON, "ovf_tcon");
    endtask

    task automatic test_irq_race();
        bus_write(A_TCON, 32'h0);
        n_vec++;
        if (oInterrupt !== 1'b0) begin
            n_miss++;
            $display("FAIL race_irq_cleared: got %b, expected 0", oInterrupt);
        end
        bus_write(A_TL, 32'hFFFFFFFD);
        bus_write(A_TCON, 32'h3);
        repeat (2) @(negedge clk);
        exp_q.push_back(32'hFFFFFFFF);
        sb_read(A_TL, "race_tl_max");
        // Clear write lands on the overflow edge
        bus_write(A_TCON, 32'h3);
        n_vec++;
        if (oInterrupt !== 1'b1) begin
            n_miss++;
            $display("FAIL race_irq_kept: got %b, expected 1", oInterrupt);
        end
        exp_q.push_back(32'h7);
        sb_read(A_TCON, "race_tcon");
        exp_q.push_back(32'hFFFFFFFC);
        sb_read(A_TL, "race_tl_reload");
        bus_write(A_TCON, 32'h3);
        n_vec++;
        if (oInterrupt !== 1'b0) begin
            n_miss++;
            $display("FAIL race_irq_clear: got %b, expected 0", oInterrupt);
        end
        exp_q.push_back(32'h3);
        sb_read(A_TCON, "race_tcon_clear");
    endtask

    task automatic test_ie_off();
        bus_write(A_TCON, 32'h0);
        bus_write(A_TH, 32'h12345678);
        bus_write(A_TL, 32'hFFFFFFFF);
        bus_write(A_TCON, 32'h1);
        exp_q.push_back(32'hFFFFFFFF);
        sb_read(A_TL, "ieoff_tl_max");
        @(negedge clk);
        exp_q.push_back(32'h12345678);
        sb_read(A_TL, "ieoff_tl_reload");
        n_vec++;
        if (oInterrupt !== 1'b0) begin
            n_miss++;
            $display("FAIL ieoff_irq: got %b, expected 0", oInterrupt);
        end
        exp_q.push_back(32'h1);
        sb_read(A_TCON, "ieoff_tcon");
        bus_write(A_TCON, 32'h0);
    endtask

    task automatic test_back_to_back();
        // TH write on a reload edge: TL gets the old TH
        bus_write(A_TH, 32'h100);
        bus_write(A_TL, 32'hFFFFFFFE);
        bus_write(A_TCON, 32'h1);
        @(negedge clk);
        bus_write(A_TH, 32'h200);
        exp_q.push_back(32'h100);
        sb_read(A_TL, "b2b_reload_old_th");
        exp_q.push_back(32'h200);
        sb_read(A_TH, "b2b_th_new");
        // TL write while counting: the write wins over the increment
        bus_write(A_TL, 32'h5);
        exp_q.push_back(32'h5);
        sb_read(A_TL, "b2b_tl_write_wins");
        @(negedge clk);
        exp_q.push_back(32'h6);
        sb_read(A_TL, "b2b_tl_inc");
        // Software-forced interrupt
        bus_write(A_TCON, 32'h4);
        n_vec++;
        if (oInterrupt !== 1'b1) begin
            n_miss++;
            $display("FAIL b2b_force_irq: got %b, expected 1", oInterrupt);
        end
        bus_write(A_TCON, 32'h0);
    endtask

    task automatic test_led_digi_switch();
        bus_write(A_LED, 32'h1A5);
        n_vec++;
        if (oLed !== 8'hA5) begin
            n_miss++;
            $display("FAIL led_out: got %h, expected a5", oLed);
        end
        exp_q.push_back(32'hA5);
        sb_read(A_LED, "led_read");
        bus_write(A_DIGI, 32'hFABC);
        n_vec++;
        if (oDigi !== 12'hABC) begin
            n_miss++;
            $display("FAIL digi_out: got %h, expected abc", oDigi);
        end
        exp_q.push_back(32'hABC);
        sb_read(A_DIGI, "digi_read");
        iSwitch = 8'h3C;
        exp_q.push_back(32'h0);
        sb_read(A_SWITCH, "sw_edge0");
        @(negedge clk);
        exp_q.push_back(32'h0);
        sb_read(A_SWITCH, "sw_edge1");
        @(negedge clk);
        exp_q.push_back(32'h3C);
        sb_read(A_SWITCH, "sw_edge2");
        bus_write(A_SWITCH, 32'hFF);
        exp_q.push_back(32'h3C);
        sb_read(A_SWITCH, "sw_write_ignored");
    endtask

    task automatic test_decode();
        exp_q.push_back(32'h0);
        sb_read(A_UNMAP, "dec_unmapped");
        exp_q.push_back(32'h0);
        sb_read(32'h50000000, "dec_other_base");
        bus_write(A_UNMAP, 32'hFFFFFFFF);
        bus_write(32'h50000000, 32'hDEAD);
        bus_write(32'h5000000C, 32'h11);
        exp_q.push_back(32'h200);
        sb_read(A_TH, "dec_th_unchanged");
        n_vec++;
        if (oLed !== 8'hA5) begin
            n_miss++;
            $display("FAIL dec_led_unchanged: got %h, expected a5", oLed);
        end
        // Byte-lane bits ignored
        exp_q.push_back(32'hA5);
        sb_read(A_LED + 32'h3, "dec_byte_lane");
        // No read strobe: bus returns zero
        iMemAddr = A_TH;
        iMemRead = 1'b0;
        #1;
        n_vec++;
        if (oMemReadData !== 32'h0) begin
            n_miss++;
            $display("FAIL dec_no_strobe: got %h, expected 0", oMemReadData);
        end
        iMemAddr = 32'h0;
    endtask

    task automatic test_systick();
`ifdef TIMER_PERIPHERAL_SYSTICK_EN
        bus_write(A_SYSTICK, 32'd100);
        exp_q.push_back(32'd100);
        sb_read(A_SYSTICK, "systick_load");
        repeat (3) @(negedge clk);
        exp_q.push_back(32'd103);
        sb_read(A_SYSTICK, "systick_count");
`else
        exp_q.push_back(32'h0);
        sb_read(A_SYSTICK, "systick_absent");
        bus_write(A_SYSTICK, 32'd100);
        exp_q.push_back(32'h0);
        sb_read(A_SYSTICK, "systick_absent_wr");
`endif
    endtask

    initial begin
        reset         = 1'b0;
        iMemAddr      = 32'h0;
        iMemWrite     = 1'b0;
        iMemRead      = 1'b0;
        iMemWriteData = 32'h0;
        iSwitch       = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        test_reset();
        test_overflow();
        test_irq_race();
        test_ie_off();
        test_back_to_back();
        test_led_digi_switch();
        test_decode();
        test_systick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
